// File: rtl/bp_bht_btb.sv
// Dynamic branch predictor: direct-mapped BHT/BTB in flops, combinational lookup and mispredict.
// Optional BP_PERF_CNT_EN adds perf_lookups / perf_mispredicts counters.
module bp_bht_btb #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned TAG_BITS = 6,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lk_pc,
    output logic        lk_taken,
    output logic [15:0] lk_target,
    output logic        lk_hit,
    input  logic        stall,
    input  logic        upd_valid,
    input  logic        upd_cond,
    input  logic [15:0] upd_pc,
    input  logic        upd_taken,
    input  logic [15:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [15:0] upd_pred_target,
    output logic        mispredict,
`ifdef BP_PERF_CNT_EN
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_mispredicts,
`endif
    output logic [15:0] redirect_pc
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [15:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_qual;
    logic                upd_hit;
    logic [CTR_BITS-1:0] ctr_cur;

    logic                wr_en;
    logic [TAG_BITS-1:0] nxt_tag;
    logic [15:0]         nxt_target;
    logic [CTR_BITS-1:0] nxt_ctr;

    // Only the index/tag fields of the PCs feed the table; the rest is folded here.
    logic                lint_unused;
    assign lint_unused = ^{lk_pc, upd_pc};

    // Lookup path: no bypass from a same-cycle update.
    always_comb begin
        lk_idx    = lk_pc[IDX_BITS:1];
        lk_tag    = lk_pc[IDX_BITS+TAG_BITS:IDX_BITS+1];
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
        lk_target = lk_taken ? target_q[lk_idx] : lk_pc + 16'd2;
    end

    always_comb begin
        upd_idx     = upd_pc[IDX_BITS:1];
        upd_tag     = upd_pc[IDX_BITS+TAG_BITS:IDX_BITS+1];
        upd_qual    = rst_n && upd_valid && !stall;
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        mispredict  = upd_qual && ((upd_pred_taken != upd_taken) ||
                                   (upd_taken && (upd_pred_target != upd_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + 16'd2;
    end

    // Next contents of the indexed entry; a miss-taken allocates over any occupant.
    always_comb begin
        ctr_cur    = ctr_q[upd_idx];
        wr_en      = 1'b0;
        nxt_tag    = tag_q[upd_idx];
        nxt_target = target_q[upd_idx];
        nxt_ctr    = ctr_cur;
        if (upd_qual) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (!upd_cond) begin
                    nxt_ctr = CTR_MAX;
                end else if (upd_taken) begin
                    nxt_ctr = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_BITS'(1);
                end else begin
                    nxt_ctr = (ctr_cur == CTR_ZERO) ? ctr_cur : ctr_cur - CTR_BITS'(1);
                end
                if (upd_taken) begin
                    nxt_target = upd_target;
                end
            end else if (upd_taken) begin
                wr_en      = 1'b1;
                nxt_tag    = upd_tag;
                nxt_target = upd_target;
                nxt_ctr    = upd_cond ? CTR_WEAK : CTR_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= nxt_tag;
            target_q[upd_idx] <= nxt_target;
            ctr_q[upd_idx]    <= nxt_ctr;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lookups     <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (upd_qual) begin
                perf_lookups <= perf_lookups + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_bht_btb.sv
// Self-checking bench for bp_bht_btb: directed plan steps plus randomized traffic against a table model.
module tb_bp_bht_btb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lk_pc;
    logic        lk_taken;
    logic [15:0] lk_target;
    logic        lk_hit;
    logic        stall;
    logic        upd_valid;
    logic        upd_cond;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;
`endif

    int checks = 0;
    int failures = 0;

    // Model: 16 entries, index = (pc/2) mod 16, tag = (pc/32) mod 64, counter 0..3.
    bit          m_valid  [16];
    int          m_tag    [16];
    logic [15:0] m_target [16];
    int          m_ctr    [16];
    int          m_lookups = 0;
    int          m_mispr   = 0;

    bp_bht_btb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lk_pc           (lk_pc),
        .lk_taken        (lk_taken),
        .lk_target       (lk_target),
        .lk_hit          (lk_hit),
        .stall           (stall),
        .upd_valid       (upd_valid),
        .upd_cond        (upd_cond),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
`ifdef BP_PERF_CNT_EN
        .perf_lookups    (perf_lookups),
        .perf_mispredicts(perf_mispredicts),
`endif
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) / 2) % 16;
    endfunction

    function automatic int tag_of(input logic [15:0] pc);
        return (int'(pc) / 32) % 64;
    endfunction

    task automatic model_lookup(input logic [15:0] pc, output logic hit, output logic taken,
                                output logic [15:0] target);
        int i;
        i      = idx_of(pc);
        hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
        taken  = hit && (m_ctr[i] >= 2);
        target = taken ? m_target[i] : pc + 16'd2;
    endtask

    function automatic logic exp_mispredict();
        return rst_n && upd_valid && !stall &&
               ((upd_pred_taken != upd_taken) || (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    task automatic model_update(input logic em);
        int i;
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_target[k] = '0; m_ctr[k] = 0;
            end
            m_lookups = 0;
            m_mispr   = 0;
        end else if (upd_valid && !stall) begin
            m_lookups++;
            if (em) m_mispr++;
            i = idx_of(upd_pc);
            if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
                if (!upd_cond)     m_ctr[i] = 3;
                else if (upd_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                if (upd_taken) m_target[i] = upd_target;
            end else if (upd_taken) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(upd_pc);
                m_target[i] = upd_target;
                m_ctr[i]    = upd_cond ? 2 : 3;
            end
        end
    endtask

    // Check all outputs against the model, then clock the edge into both.
    task automatic cycle(input string tag);
        logic eh, et, em;
        logic [15:0] etg, er;
        #1;
        model_lookup(lk_pc, eh, et, etg);
        em = exp_mispredict();
        er = upd_taken ? upd_target : upd_pc + 16'd2;
        chk({tag, ".hit"},      32'(lk_hit),      32'(eh));
        chk({tag, ".taken"},    32'(lk_taken),    32'(et));
        chk({tag, ".target"},   32'(lk_target),   32'(etg));
        chk({tag, ".mispr"},    32'(mispredict),  32'(em));
        chk({tag, ".redirect"}, 32'(redirect_pc), 32'(er));
        @(posedge clk);
        model_update(em);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic c, input logic [15:0] pc, input logic t,
                           input logic [15:0] tg, input logic pt, input logic [15:0] ptg);
        upd_valid = v; upd_cond = c; upd_pc = pc; upd_taken = t;
        upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg;
    endtask

    // Constant-expectation lookup probe (no clock advance).
    task automatic peek(input string tag, input logic [15:0] pc, input logic h, input logic t,
                        input logic [15:0] tg);
        lk_pc = pc;
        #1;
        chk({tag, ".hit"},    32'(lk_hit),    32'(h));
        chk({tag, ".taken"},  32'(lk_taken),  32'(t));
        chk({tag, ".target"}, 32'(lk_target), 32'(tg));
    endtask

    function automatic logic [15:0] pool_pc(input int k);
        case (k)
            0: return 16'h3010;
            1: return 16'h3110;
            2: return 16'h3100;
            3: return 16'h3012;
            4: return 16'h0000;
            5: return 16'hFFFE;
            6: return 16'h4010;
            default: return 16'h3014;
        endcase
    endfunction

    initial begin
        logic h, t;
        logic [15:0] tg, pc;

        rst_n = 1'b0; stall = 1'b0; lk_pc = 16'h3000;
        // Mispredicting update presented during reset must not flag.
        set_upd(1'b1, 1'b1, 16'h3010, 1'b1, 16'h3040, 1'b0, 16'h0000);
        cycle("rst0");
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cycle("rst1");
        rst_n = 1'b1;

        peek("reset_lk", 16'h3000, 1'b0, 1'b0, 16'h3002);
        chk("reset_mispr", 32'(mispredict), 32'd0);

        // Allocate on taken mispredict.
        set_upd(1'b1, 1'b1, 16'h3010, 1'b1, 16'h3040, 1'b0, 16'h3012);
        #1;
        chk("alloc_mispr", 32'(mispredict), 32'd1);
        chk("alloc_redir", 32'(redirect_pc), 32'h3040);
        cycle("alloc");
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        peek("alloc_lk", 16'h3010, 1'b1, 1'b1, 16'h3040);

        // Not-taken twice: counter 2 -> 1 -> 0.
        set_upd(1'b1, 1'b1, 16'h3010, 1'b0, 16'h3040, 1'b1, 16'h3040);
        #1;
        chk("nt1_mispr", 32'(mispredict), 32'd1);
        chk("nt1_redir", 32'(redirect_pc), 32'h3012);
        cycle("nt1");
        set_upd(1'b1, 1'b1, 16'h3010, 1'b0, 16'h3040, 1'b0, 16'h3012);
        cycle("nt2");
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        peek("nt_lk", 16'h3010, 1'b1, 1'b0, 16'h3012);

        // Miss not-taken: no allocation.
        set_upd(1'b1, 1'b1, 16'h3100, 1'b0, 16'h3200, 1'b0, 16'h3102);
        cycle("miss_nt");
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        peek("miss_nt_lk", 16'h3100, 1'b0, 1'b0, 16'h3102);

        // Alias replaces the index-8 occupant.
        set_upd(1'b1, 1'b1, 16'h3110, 1'b1, 16'h3150, 1'b1, 16'h3150);
        cycle("alias");
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        peek("alias_old", 16'h3010, 1'b0, 1'b0, 16'h3012);
        peek("alias_new", 16'h3110, 1'b1, 1'b1, 16'h3150);
`ifdef BP_PERF_CNT_EN
        chk("perf_lookups5", perf_lookups, 32'd5);
        chk("perf_mispr2", perf_mispredicts, 32'd2);
`endif

        // Stall holds the table and suppresses mispredict.
        stall = 1'b1;
        set_upd(1'b1, 1'b0, 16'h3200, 1'b1, 16'h3300, 1'b0, 16'h3202);
        #1;
        chk("stall_mispr", 32'(mispredict), 32'd0);
        cycle("stall");
        peek("stall_lk", 16'h3200, 1'b0, 1'b0, 16'h3202);
        stall = 1'b0;
        #1;
        chk("unstall_mispr", 32'(mispredict), 32'd1);
        cycle("unstall");
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        peek("unstall_lk", 16'h3200, 1'b1, 1'b1, 16'h3300);

        // PC+2 wrap on both paths.
        set_upd(1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h1234, 1'b1, 16'h1234);
        peek("wrap_lk", 16'hFFFE, 1'b0, 1'b0, 16'h0000);
        chk("wrap_redir", 32'(redirect_pc), 32'h0000);
        cycle("wrap");

        // Randomized traffic over a small PC pool so entries alias and reuse.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 4) == 0);
            lk_pc = pool_pc(int'($urandom_range(0, 7)));
            pc    = pool_pc(int'($urandom_range(0, 7)));
            model_lookup(pc, h, t, tg);
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_cond  = ($urandom_range(0, 3) != 0);
            upd_pc    = pc;
            upd_taken = !upd_cond || $urandom_range(0, 1) == 1;
            upd_target = ($urandom_range(0, 1) == 1) ? 16'h3040 : 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 9) < 7) begin
                upd_pred_taken  = t;
                upd_pred_target = tg;
            end else begin
                upd_pred_taken  = 1'($urandom_range(0, 1));
                upd_pred_target = 16'($urandom_range(0, 65535));
            end
            cycle("rand");
        end
        rst_n = 1'b1;
        stall = 1'b0;
`ifdef BP_PERF_CNT_EN
        chk("perf_lookups_rand", perf_lookups, 32'(m_lookups));
        chk("perf_mispr_rand", perf_mispredicts, 32'(m_mispr));
`endif

        // Mid-stream reset with a concurrent update: table clears, update dropped.
        rst_n = 1'b0;
        set_upd(1'b1, 1'b0, 16'h3010, 1'b1, 16'h3040, 1'b0, 16'h3012);
        cycle("midrst");
        rst_n = 1'b1;
        set_upd(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        peek("midrst_lk", 16'h3010, 1'b0, 1'b0, 16'h3012);
        peek("midrst_lk2", 16'h3200, 1'b0, 1'b0, 16'h3202);
`ifdef BP_PERF_CNT_EN
        chk("perf_lookups_rst", perf_lookups, 32'd0);
        chk("perf_mispr_rst", perf_mispredicts, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_bht_btb.md
# bp_bht_btb

Parametrised dynamic branch predictor with a branch history table and branch target buffer. It replaces the fixed predict-not-taken flush logic of the pipelined LC-3b core. IF looks it up every cycle to choose the next PC. MEM writes back the resolved outcome, and the block raises a mispredict and redirect for the flush path when the prediction was wrong.

## Interface
Parameters:
- `IDX_BITS`, default 4: table has 2^IDX_BITS entries; index = `pc[IDX_BITS:1]`.
- `TAG_BITS`, default 6: tag = `pc[IDX_BITS+TAG_BITS:IDX_BITS+1]`; must satisfy IDX_BITS+TAG_BITS ≤ 15.
- `CTR_BITS`, default 2: saturating counter width, 1..4.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: reset, synchronous, active-low.
- `lk_pc` in, 16: IF-stage PC being fetched.
- `lk_taken` out, 1: prediction is taken.
- `lk_target` out, 16: predicted target; equals `lk_pc+2` when `lk_taken`=0.
- `lk_hit` out, 1: valid entry with matching tag.
- `stall` in, 1: pipeline stall; suppresses updates and mispredict.
- `upd_valid` in, 1: the MEM-stage instruction is a resolved control transfer (br/jmp/jsr/trap).
- `upd_cond` in, 1: 1 = conditional BR; 0 = unconditional.
- `upd_pc` in, 16: PC of the resolved instruction.
- `upd_taken` in, 1: actual outcome.
- `upd_target` in, 16: actual taken target.
- `upd_pred_taken` in, 1: prediction carried down the pipe for this instruction.
- `upd_pred_target` in, 16: predicted target carried down the pipe.
- `mispredict` out, 1: flush IF/ID and ID/EX, load `redirect_pc`.
- `redirect_pc` out, 16: correct next PC.

## Operation
- Storage per entry: valid bit, TAG_BITS tag, 16-bit target, CTR_BITS counter. All entries are flops, not RAM.
- Lookup is combinational from the table state.
  - `lk_hit` = valid[idx] & (tag[idx] == lk tag).
  - `lk_taken` = `lk_hit` & ctr[idx] MSB.
  - `lk_target` = `lk_taken` ? target[idx] : `lk_pc+2`, modulo 2^16.
- Update is qualified by `upd_valid & ~stall`.
- Hit on `upd_pc`:
  - Conditional: counter increments on taken, decrements on not-taken, saturating at 0 and 2^CTR_BITS−1.
  - Unconditional: counter is set to max.
  - Target is overwritten with `upd_target` when taken.
- Miss on `upd_pc`:
  - Taken: allocate the entry. Set valid, write tag and target, set counter to 2^(CTR_BITS−1) (weakly taken), or to max if unconditional. This replaces any existing occupant.
  - Not-taken: no allocation; table unchanged.
- `mispredict` = `upd_valid & ~stall & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target))`.
- `redirect_pc` = `upd_taken` ? `upd_target` : `upd_pc+2`. It is driven at all times; it is meaningful only while `mispredict`=1.
- With CTR_BITS=1 the counter is a last-outcome bit; "weakly taken" = 1.

## Timing
- Reset (`rst_n`=0 at a rising edge): all valid bits 0, counters 0, tags and targets 0.
- Output values while no entry is valid:
  - `lk_hit`=0, `lk_taken`=0, `lk_target`=`lk_pc+2`.
  - `mispredict`=0 whenever `upd_valid`=0.
  - During reset cycles `mispredict` is forced 0.
- Lookup latency is 0 cycles (combinational from `lk_pc`).
- An update becomes visible to lookup on the cycle after the qualifying edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents; there is no bypass.
- `mispredict` is combinational in the same cycle as the update. The consumer registers the PC on that edge.
- `stall`=1 with `upd_valid`=1: no table write, `mispredict`=0. The update is re-presented when the stall releases.
- Reset asserted mid-stream: the table clears at that edge and any concurrent update is dropped.
- `upd_pc+2` and `lk_pc+2` wrap: 0xFFFE+2 = 0x0000.

## Configuration
- `BP_PERF_CNT_EN` defined: adds output ports `perf_lookups` (32 bits) and `perf_mispredicts` (32 bits).
  - `perf_lookups` increments on every qualified update.
  - `perf_mispredicts` increments when `mispredict`=1.
  - Both are cleared by reset and wrap at 2^32.
- `BP_PERF_CNT_EN` undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then `lk_pc`=0x3000 → `lk_hit`=0, `lk_taken`=0, `lk_target`=0x3002.
- Conditional update pc=0x3010, taken, target=0x3040, pred_taken=0 → `mispredict`=1, `redirect_pc`=0x3040. Next cycle lookup 0x3010 → hit, taken, target 0x3040 (CTR_BITS=2, counter=2).
- Same branch not-taken twice (pred_taken=1 the first time) → first `mispredict`=1 with `redirect_pc`=0x3012. Counter ends at 0; lookup then gives hit=1, taken=0, target=0x3012.
- Not-taken update for pc=0x3100 on a miss → no allocation, lookup stays hit=0. Aliasing pc=0x3110 (same index, different tag) taken → entry replaced, 0x3010 now misses.
- `stall`=1 with a mispredicting update → `mispredict`=0 and the table is unchanged. Deassert `stall` → `mispredict`=1 and the table updates.
- With `BP_PERF_CNT_EN` defined: 5 updates with 2 mispredicts → `perf_lookups`=5, `perf_mispredicts`=2. Assert `rst_n`=0 for one edge → both read 0.
